uart_spi_selftest_system: RTL and testbench
===========================================

Name: uart_spi_selftest_system

Overview:
- Self-contained I/O subsystem with two UART receivers (rxd and rxd2), one UART transmitter (txd2) and a mode-0 SPI master.
- A control FSM forwards each byte received on rxd to both txd2 and the SPI master.
- rxd2 is normally tied externally to txd2, and the returned byte is checked as a loopback self-test.
- After reset the block runs a boot self-test with a fixed byte; it then sits at the top of the board design as the serial/SPI front end.

Parameters:
- BAUD_DIV, 156: clk cycles per UART bit (1560 ns per bit at a 100 MHz clk).
- SPI_DIV, 4: clk cycles per sck half-period.
- BOOT_BYTE, 8'h55: byte sent on txd2 and SPI after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rxd  in  1  UART command input, idle high.
- rxd2  in  1  UART loopback input, idle high.
- txd2  out  1  UART output, idle high.
- sck  out  1  SPI clock.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in.
- rx_byte  out  8  last valid byte received on rxd.
- rx_valid  out  1  one-cycle pulse when rx_byte updates.
- spi_rx  out  8  byte captured from miso in the last transfer.
- spi_done  out  1  one-cycle pulse at the end of a transfer.
- lb_ok  out  1  sticky; last loopback byte matched.
- lb_err  out  1  sticky; last loopback byte mismatched or a loopback timeout occurred.
- overrun  out  1  sticky; an rxd byte was dropped while the block was busy.

Behaviour:
- Reset values: txd2=1, sck=0, mosi=0; rx_byte, spi_rx=0; every pulse and flag output = 0; FSM in BOOT. Reset asserted mid-operation aborts all activity immediately.
- UART framing: 8N1, LSB first.
- UART receivers:
  - Input passes through a 2-flop synchronizer.
  - Start is detected on a falling edge.
  - The line is re-sampled at BAUD_DIV/2; if it is high, the start is false and the receiver aborts.
  - Data bits are sampled every BAUD_DIV cycles thereafter.
  - The stop bit must be 1; otherwise the byte is discarded with no pulse.
- UART transmitter: each bit is held BAUD_DIV cycles: start(0), d0..d7, stop(1).
- SPI master, mode 0, MSB first:
  - mosi is set up before the first rising sck edge and updated on each falling edge.
  - miso is sampled on each rising edge.
  - 8 sck periods per transfer; sck returns low and mosi returns 0 at the end.
  - spi_rx is loaded and spi_done pulses one cycle after the final falling edge.
- FSM states:
  - BOOT: the first cycle after reset release. Load BOOT_BYTE and go to XFER.
  - XFER: start UART tx and SPI in the same cycle with the same byte, then go to WAIT.
  - WAIT: stay until both the UART tx and SPI are done and the loopback byte has arrived, or a timeout of 12*BAUD_DIV cycles from tx start expires. Then go to IDLE.
  - IDLE: on rx_valid from rxd, latch the byte and go to XFER.
- Loopback check:
  - A byte received on rxd2 while in WAIT is compared with the transmitted byte.
  - Equal: lb_ok=1, lb_err=0. Different, or timeout: lb_err=1, lb_ok=0.
  - rxd2 bytes received outside WAIT are ignored.
- rxd activity:
  - The rxd receiver runs in every state; rx_byte and rx_valid always update on a valid byte.
  - A byte completing outside IDLE is not forwarded and sets overrun.
  - A byte completing in the same cycle WAIT exits to IDLE is forwarded.
- Flags (lb_ok, lb_err, overrun) clear only on reset.

Decomposition:
- Shared package: FSM state enum (BOOT, XFER, WAIT, IDLE), UART frame length constant (10 bits), default BAUD_DIV/SPI_DIV/BOOT_BYTE.
- Natural sub-module: uart_rx, instantiated twice (rxd, rxd2).
- UART tx and SPI master are small enough to stay inline.

Test Plan:
- Boot with rxd2 tied to txd2, miso=1: txd2 emits 0x55 LSB first (1,0,1,0,1,0,1,0) at 1560 ns per bit; mosi shows 0,1,0,1,0,1,0,1 on successive sck rising edges; spi_rx=0xFF; lb_ok=1, lb_err=0.
- Inject 0x41 on rxd (1560 ns per bit) after boot: rx_valid pulses with rx_byte=0x41; txd2 frame carries 0x41; mosi carries 0x41 MSB first; lb_ok stays 1.
- miso driven 0xA5 MSB first on sck rising edges: spi_rx=0xA5 with a single spi_done pulse.
- rxd2 held high (loopback broken): after 12*BAUD_DIV cycles lb_err=1, lb_ok=0; FSM returns to IDLE and accepts the next rxd byte.
- Second rxd byte sent while WAIT is active: overrun=1 and no second XFER; rx_byte still shows the new value.
- Reset pulse mid SPI/UART transfer: txd2=1, sck=0, flags cleared; after release the boot 0x55 sequence restarts from its start bit.

Source files
------------

// File: rtl/uart_spi_selftest_system_pkg.sv
// uart_spi_selftest_system_pkg: shared states, frame length and default parameters
package uart_spi_selftest_system_pkg;
  typedef enum logic [1:0] {S_BOOT, S_XFER, S_WAIT, S_IDLE} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam int FRAME_BITS = 10;
  localparam int BAUD_DIV_DEF = 156;
  localparam int SPI_DIV_DEF = 4;
  localparam logic [7:0] BOOT_BYTE_DEF = 8'h55;
endpackage

// File: rtl/uart_spi_selftest_system_if.sv
// uart_spi_selftest_system_if: serial lines, SPI pins and status outputs of the front end
interface uart_spi_selftest_system_if;
  logic rxd, rxd2, txd2, sck, mosi, miso;
  logic [7:0] rx_byte, spi_rx;
  logic rx_valid, spi_done, lb_ok, lb_err, overrun;
  modport master(input rxd, rxd2, miso,
                 output txd2, sck, mosi, rx_byte, rx_valid, spi_rx, spi_done, lb_ok, lb_err, overrun);
  modport slave(output rxd, rxd2, miso,
                input txd2, sck, mosi, rx_byte, rx_valid, spi_rx, spi_done, lb_ok, lb_err, overrun);
endinterface

// File: rtl/uart_spi_selftest_system_uart_rx.sv
// uart_spi_selftest_system_uart_rx: 8N1 receiver with mid-bit sampling and false-start rejection
module uart_spi_selftest_system_uart_rx
  import uart_spi_selftest_system_pkg::*;
#(parameter int BAUD_DIV = BAUD_DIV_DEF) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid
);
  rx_state_t st_q, st_d;
  logic s1_q, s2_q, s3_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, data_q, data_d;
  logic valid_q, valid_d, bit_end;
  assign bit_end = cnt_q == 16'(BAUD_DIV - 1);
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q + 16'd1;
    bit_d = bit_q;
    sh_d = sh_q;
    data_d = data_q;
    valid_d = 1'b0;
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (s3_q && !s2_q) st_d = RX_START;
      end
      RX_START: if (cnt_q == 16'(BAUD_DIV / 2 - 1)) begin
        cnt_d = '0;
        bit_d = '0;
        st_d = s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (bit_end) begin
        cnt_d = '0;
        sh_d = {s2_q, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) st_d = RX_STOP;
      end
      default: if (bit_end) begin
        st_d = RX_IDLE;
        valid_d = s2_q;
        data_d = s2_q ? sh_q : data_q;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st_q <= RX_IDLE;
      {s1_q, s2_q, s3_q} <= 3'b111;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      st_q <= st_d;
      {s1_q, s2_q, s3_q} <= {rx, s1_q, s2_q};
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  assign data = data_q;
  assign valid = valid_q;
endmodule

// File: rtl/uart_spi_selftest_system.sv
// uart_spi_selftest_system: forwards rxd bytes to a UART tx and SPI master,
// checking the UART copy looped back on rxd2.
module uart_spi_selftest_system
  import uart_spi_selftest_system_pkg::*;
#(parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int SPI_DIV = SPI_DIV_DEF,
  parameter logic [7:0] BOOT_BYTE = BOOT_BYTE_DEF) (
  input logic clk,
  input logic reset,
  uart_spi_selftest_system_if.master bus
);
  logic rx_valid, rx2_valid;
  logic [7:0] rx_data, rx2_data;
  uart_spi_selftest_system_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk(clk), .reset(reset), .rx(bus.rxd), .data(rx_data), .valid(rx_valid));
  uart_spi_selftest_system_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx2 (
    .clk(clk), .reset(reset), .rx(bus.rxd2), .data(rx2_data), .valid(rx2_valid));
  state_t st_q, st_d;
  logic [7:0] byte_q, byte_d, tx_sh_q, tx_sh_d, spi_sh_q, spi_sh_d, spi_in_q, spi_in_d, spi_rx_q, spi_rx_d;
  logic [7:0] spi_cnt_q, spi_cnt_d;
  logic [15:0] to_q, to_d, tx_cnt_q, tx_cnt_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic [2:0] spi_bit_q, spi_bit_d;
  logic got_q, got_d, ok_q, ok_d, err_q, err_d, ovr_q, ovr_d;
  logic tx_busy_q, tx_busy_d, txd_q, txd_d;
  logic spi_busy_q, spi_busy_d, spi_fin_q, spi_fin_d, sck_q, sck_d, mosi_q, mosi_d, spi_done_q, spi_done_d;
  logic start, tx_end, spi_tick, timeout, exit_wait, accept;
  assign start = st_q == S_XFER;
  assign tx_end = tx_cnt_q == 16'(BAUD_DIV - 1);
  assign spi_tick = spi_cnt_q == 8'(SPI_DIV - 1);
  assign timeout = to_q == 16'(12 * BAUD_DIV - 1);
  assign exit_wait = st_q == S_WAIT &&
                     ((got_q && !tx_busy_q && !spi_busy_q && !spi_fin_q) || timeout);
  // A byte landing exactly as WAIT finishes is still forwarded rather than dropped
  assign accept = rx_valid && (st_q == S_IDLE || exit_wait);
  always_comb begin
    st_d = st_q;
    byte_d = byte_q;
    to_d = to_q + 16'd1;
    got_d = got_q;
    ok_d = ok_q;
    err_d = err_q;
    ovr_d = ovr_q | (rx_valid & ~accept);
    case (st_q)
      S_BOOT: begin
        byte_d = BOOT_BYTE;
        st_d = S_XFER;
      end
      S_XFER: begin
        to_d = '0;
        got_d = 1'b0;
        st_d = S_WAIT;
      end
      S_WAIT: begin
        if (rx2_valid) begin
          got_d = 1'b1;
          ok_d = rx2_data == byte_q;
          err_d = rx2_data != byte_q;
        end else if (timeout && !got_q) begin
          ok_d = 1'b0;
          err_d = 1'b1;
        end
        st_d = exit_wait ? S_IDLE : S_WAIT;
      end
      default: ;
    endcase
    if (accept) begin
      byte_d = rx_data;
      st_d = S_XFER;
    end
  end
  // The tx shifter fills with ones, so the stop bit falls out after d7
  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_cnt_d = tx_busy_q && !tx_end ? tx_cnt_q + 16'd1 : '0;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    txd_d = txd_q;
    if (start) begin
      tx_busy_d = 1'b1;
      tx_bit_d = '0;
      tx_sh_d = byte_q;
      txd_d = 1'b0;
    end else if (tx_busy_q && tx_end) begin
      tx_bit_d = tx_bit_q + 4'd1;
      tx_sh_d = {1'b1, tx_sh_q[7:1]};
      txd_d = tx_sh_q[0];
      tx_busy_d = tx_bit_q != 4'(FRAME_BITS - 1);
    end
  end
  always_comb begin
    spi_busy_d = spi_busy_q;
    spi_cnt_d = spi_busy_q && !spi_tick ? spi_cnt_q + 8'd1 : '0;
    spi_bit_d = spi_bit_q;
    spi_sh_d = spi_sh_q;
    spi_in_d = spi_in_q;
    sck_d = sck_q;
    mosi_d = mosi_q;
    spi_fin_d = 1'b0;
    spi_rx_d = spi_fin_q ? spi_in_q : spi_rx_q;
    spi_done_d = spi_fin_q;
    if (start) begin
      spi_busy_d = 1'b1;
      spi_bit_d = '0;
      sck_d = 1'b0;
      mosi_d = byte_q[7];
      spi_sh_d = {byte_q[6:0], 1'b0};
    end else if (spi_busy_q && spi_tick) begin
      sck_d = ~sck_q;
      if (!sck_q) spi_in_d = {spi_in_q[6:0], bus.miso};
      else begin
        spi_bit_d = spi_bit_q + 3'd1;
        mosi_d = spi_bit_q == 3'd7 ? 1'b0 : spi_sh_q[7];
        spi_sh_d = {spi_sh_q[6:0], 1'b0};
        spi_busy_d = spi_bit_q != 3'd7;
        spi_fin_d = spi_bit_q == 3'd7;
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st_q <= S_BOOT;
      {byte_q, tx_sh_q, spi_sh_q, spi_in_q, spi_rx_q, spi_cnt_q} <= '0;
      {to_q, tx_cnt_q, tx_bit_q, spi_bit_q} <= '0;
      {got_q, ok_q, err_q, ovr_q, tx_busy_q, spi_busy_q, spi_fin_q, sck_q, mosi_q, spi_done_q} <= '0;
      txd_q <= 1'b1;
    end else begin
      st_q <= st_d;
      {byte_q, tx_sh_q, spi_sh_q, spi_in_q, spi_rx_q, spi_cnt_q} <=
        {byte_d, tx_sh_d, spi_sh_d, spi_in_d, spi_rx_d, spi_cnt_d};
      {to_q, tx_cnt_q, tx_bit_q, spi_bit_q} <= {to_d, tx_cnt_d, tx_bit_d, spi_bit_d};
      {got_q, ok_q, err_q, ovr_q, tx_busy_q, spi_busy_q, spi_fin_q, sck_q, mosi_q, spi_done_q} <=
        {got_d, ok_d, err_d, ovr_d, tx_busy_d, spi_busy_d, spi_fin_d, sck_d, mosi_d, spi_done_d};
      txd_q <= txd_d;
    end
  assign bus.txd2 = txd_q;
  assign bus.sck = sck_q;
  assign bus.mosi = mosi_q;
  assign bus.rx_byte = rx_data;
  assign bus.rx_valid = rx_valid;
  assign bus.spi_rx = spi_rx_q;
  assign bus.spi_done = spi_done_q;
  assign bus.lb_ok = ok_q;
  assign bus.lb_err = err_q;
  assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_uart_spi_selftest_system.sv
// tb_uart_spi_selftest_system: scoreboard bench; stimulus pushes expected bytes,
// independent monitors decode txd2 frames, SPI mosi/miso and rx_valid and pop them.
module tb_uart_spi_selftest_system;
  localparam int BIT_T = 1560;
  logic clk = 0, reset = 0, lb_en = 1;
  logic [7:0] miso_pat = 8'hFF;
  logic [2:0] miso_i;
  int sck_falls = 0, miso_base = 0, epoch = 0, total = 0, bad = 0;
  logic [7:0] q_tx[$], q_spi[$], q_miso[$], q_rx[$];
  always #5 clk = ~clk;
  uart_spi_selftest_system_if bus();
  uart_spi_selftest_system dut(.clk(clk), .reset(reset), .bus(bus));
  assign bus.rxd2 = lb_en ? bus.txd2 : 1'b1;
  always @(negedge bus.sck) sck_falls++;
  always @(negedge reset) epoch++;
  assign miso_i = 3'(7 - (sck_falls - miso_base));
  assign bus.miso = miso_pat[miso_i];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic set_miso(logic [7:0] m);
    miso_pat = m;
    miso_base = sck_falls;
    q_miso.push_back(m);
  endtask

  task automatic expect_xfer(logic [7:0] b, logic [7:0] m);
    q_rx.push_back(b);
    q_tx.push_back(b);
    q_spi.push_back(b);
    set_miso(m);
  endtask

  task automatic send_uart(logic [7:0] b);
    bus.rxd = 0;
    #BIT_T;
    for (int i = 0; i < 8; i++) begin
      bus.rxd = b[i];
      #BIT_T;
    end
    bus.rxd = 1;
    #BIT_T;
  endtask

  task automatic reset_checks();
    chk("rst_txd2", bus.txd2, 1);
    chk("rst_sck", bus.sck, 0);
    chk("rst_mosi", bus.mosi, 0);
    chk("rst_rx_byte", bus.rx_byte, 0);
    chk("rst_spi_rx", bus.spi_rx, 0);
    chk("rst_pulses", {bus.rx_valid, bus.spi_done}, 0);
    chk("rst_flags", {bus.lb_ok, bus.lb_err, bus.overrun}, 0);
  endtask

  task automatic flags(string nm, logic ok, logic err, logic ovr);
    chk(nm, {bus.lb_ok, bus.lb_err, bus.overrun}, {29'd0, ok, err, ovr});
  endtask

  // txd2 frame monitor: samples mid-bit; frames cut by a reset are discarded
  initial forever begin
    logic [7:0] b;
    logic st, sp;
    int ep;
    @(negedge bus.txd2);
    ep = epoch;
    #(BIT_T / 2);
    st = bus.txd2;
    for (int i = 0; i < 8; i++) begin
      #BIT_T;
      b[i] = bus.txd2;
    end
    #BIT_T;
    sp = bus.txd2;
    if (ep == epoch && reset) begin
      if (q_tx.size() == 0) chk("tx_unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
      else begin
        chk("tx_start_bit", st, 0);
        chk("tx_byte", b, q_tx.pop_front());
        chk("tx_stop_bit", sp, 1);
      end
    end
  end

  initial begin
    logic [7:0] sh = 0;
    int n = 0, ep = 0;
    forever begin
      @(posedge bus.sck);
      #1;
      if (ep != epoch) begin
        n = 0;
        ep = epoch;
      end
      sh = {sh[6:0], bus.mosi};
      n++;
      if (n == 8) begin
        n = 0;
        if (q_spi.size() == 0) chk("spi_unexpected", {24'd0, sh}, 32'hFFFF_FFFF);
        else chk("spi_mosi", sh, q_spi.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      if (q_rx.size() == 0) chk("rx_unexpected", {24'd0, bus.rx_byte}, 32'hFFFF_FFFF);
      else chk("rx_byte", bus.rx_byte, q_rx.pop_front());
    end
    if (bus.spi_done === 1'b1) begin
      chk("spi_idle_lines", {bus.sck, bus.mosi}, 0);
      if (q_miso.size() == 0) chk("spi_done_unexpected", {24'd0, bus.spi_rx}, 32'hFFFF_FFFF);
      else chk("spi_rx", bus.spi_rx, q_miso.pop_front());
    end
  end

  initial begin
    logic [7:0] b, b2, m;
    int i;
    bus.rxd = 1;
    repeat (5) @(negedge clk);
    reset_checks();
    q_tx.push_back(8'h55);
    q_spi.push_back(8'h55);
    set_miso(8'hFF);
    reset = 1;
    repeat (2200) @(negedge clk);
    flags("boot_flags", 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      b = k == 0 ? 8'h41 : 8'($urandom);
      m = k == 0 ? 8'hA5 : 8'($urandom);
      expect_xfer(b, m);
      send_uart(b);
      repeat (2200) @(negedge clk);
      flags("fwd_flags", 1, 0, 0);
    end
    lb_en = 0;
    b = 8'($urandom);
    b2 = ~b;
    expect_xfer(b, 8'($urandom));
    send_uart(b);
    q_rx.push_back(b2);
    send_uart(b2);
    chk("overrun_rx_byte", bus.rx_byte, b2);
    chk("overrun_set", bus.overrun, 1);
    repeat (400) @(negedge clk);
    flags("timeout_flags", 0, 1, 1);
    lb_en = 1;
    b = 8'($urandom);
    expect_xfer(b, 8'($urandom));
    send_uart(b);
    repeat (2200) @(negedge clk);
    flags("after_timeout_flags", 1, 0, 1);
    b = 8'($urandom);
    q_rx.push_back(b);
    set_miso(8'($urandom));
    void'(q_miso.pop_back());
    fork
      send_uart(b);
    join_none
    i = 0;
    while (bus.sck !== 1'b1 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    chk("spi_started_before_reset", i < 3000, 1);
    repeat (10) @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    reset_checks();
    wait fork;
    repeat (2000) @(negedge clk);
    q_tx.push_back(8'h55);
    q_spi.push_back(8'h55);
    set_miso(8'($urandom));
    reset = 1;
    repeat (2200) @(negedge clk);
    flags("reboot_flags", 1, 0, 0);
    chk("q_tx_drained", q_tx.size(), 0);
    chk("q_spi_drained", q_spi.size(), 0);
    chk("q_miso_drained", q_miso.size(), 0);
    chk("q_rx_drained", q_rx.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
